// File: rtl/nat_split_sched_if.sv
// Handshake bundle between the upstream drive source, the split sequencer
// and its N downstream branches.
interface nat_split_sched_if #(
    parameter int N_BRANCH = 2
);
    logic                drive;
    logic [N_BRANCH-1:0] branch_mask;
    logic [N_BRANCH-1:0] free_next;
    logic                clr_err;
    logic [N_BRANCH-1:0] drive_next;
    logic                free;
    logic                busy;
    logic                timeout;
    logic                overrun;
    logic [N_BRANCH-1:0] err_mask;

    modport master (
        output drive, branch_mask, free_next, clr_err,
        input  drive_next, free, busy, timeout, overrun, err_mask
    );

    modport slave (
        input  drive, branch_mask, free_next, clr_err,
        output drive_next, free, busy, timeout, overrun, err_mask
    );
endinterface

// File: rtl/nat_split_sched.sv
// 1-to-N unconditional split sequencer: forks one drive token to the enabled
// branches, collects every branch free, then returns one delayed free upstream.
module nat_split_sched #(
    parameter int N_BRANCH = 2,
    parameter int FREE_DLY = 2,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input logic              clk,
    input logic              rst,
    nat_split_sched_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DELAY = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(FREE_DLY);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]          state, state_n;
    logic [N_BRANCH-1:0] mask, mask_n;
    logic [N_BRANCH-1:0] pending, pending_n;
    logic [CNT_W-1:0]    dcnt, dcnt_n;
    logic [CNT_W-1:0]    tcnt, tcnt_n;
    logic                timeout_n;
    logic                overrun_n;
    logic [N_BRANCH-1:0] err_mask_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_ONE;
    endfunction

    // Next-state decode
    always_comb begin
        state_n    = state;
        mask_n     = mask;
        pending_n  = pending;
        dcnt_n     = dcnt;
        tcnt_n     = tcnt;
        timeout_n  = bus.timeout;
        overrun_n  = bus.overrun;
        err_mask_n = bus.err_mask;

        case (state)
            S_IDLE: begin
                if (bus.drive) begin
                    mask_n  = bus.branch_mask;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // a free arriving alongside the issued drive already counts
                pending_n = mask & ~bus.free_next;
                tcnt_n    = '0;
                dcnt_n    = DLY_LOAD;
                state_n   = (pending_n == '0) ? S_DELAY : S_WAIT;
            end
            S_WAIT: begin
                pending_n = pending & ~bus.free_next;
                tcnt_n    = sat_inc(tcnt);
                if (pending_n == '0) begin
                    dcnt_n  = DLY_LOAD;
                    state_n = S_DELAY;
                end else if ((TIMEOUT != 0) && (tcnt_n >= TO_LIMIT)) begin
                    timeout_n  = 1'b1;
                    err_mask_n = pending_n;
                    state_n    = S_ERR;
                end
            end
            S_DELAY: begin
                if (dcnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    dcnt_n = sat_dec(dcnt);
                end
            end
            S_ERR: begin
                if (bus.clr_err) begin
                    timeout_n  = 1'b0;
                    err_mask_n = '0;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // clear beats a colliding drive, so overrun ends low in that case
        if (bus.clr_err) begin
            overrun_n = 1'b0;
        end else if (bus.drive && (state != S_IDLE)) begin
            overrun_n = 1'b1;
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            mask           <= '0;
            pending        <= '0;
            dcnt           <= '0;
            tcnt           <= '0;
            bus.drive_next <= '0;
            bus.free       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.err_mask   <= '0;
        end else begin
            state          <= state_n;
            mask           <= mask_n;
            pending        <= pending_n;
            dcnt           <= dcnt_n;
            tcnt           <= tcnt_n;
            bus.drive_next <= (state_n == S_ISSUE) ? mask_n : '0;
            bus.free       <= (state_n == S_DELAY) && (dcnt_n == '0);
            bus.busy       <= (state_n != S_IDLE);
            bus.timeout    <= timeout_n;
            bus.overrun    <= overrun_n;
            bus.err_mask   <= err_mask_n;
        end
    end
endmodule

// File: tb/tb_nat_split_sched.sv
// Directed bench for nat_split_sched: a timestamp-based reference model checked
// every cycle, plus literal latency/flag expectations per scenario.
module tb_nat_split_sched;
    localparam int NB = 2;
    localparam int FD = 2;
    localparam int TO = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nat_split_sched_if #(.N_BRANCH(NB)) bus ();

    nat_split_sched #(
        .N_BRANCH(NB),
        .FREE_DLY(FD),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation tracked by its accept cycle and the
    // cycle at which its last pending branch was collected.
    bit         m_active = 0;
    bit         m_err    = 0;
    int         m_acc    = 0;
    int         m_empty  = -1;
    logic [1:0] m_mask   = '0;
    logic [1:0] m_pend   = '0;
    logic [1:0] e_drive  = '0;
    logic [1:0] e_emask  = '0;
    logic       e_free   = 0;
    logic       e_busy   = 0;
    logic       e_to     = 0;
    logic       e_ovr    = 0;

    task automatic model_step(input int t);
        if (rst) begin
            m_active = 0; m_err = 0; m_empty = -1; m_pend = '0;
            e_drive = '0; e_free = 0; e_busy = 0; e_to = 0; e_ovr = 0; e_emask = '0;
            return;
        end
        if (bus.clr_err) e_ovr = 0;
        else if (bus.drive && m_active) e_ovr = 1;
        if (m_active && m_err) begin
            if (bus.clr_err) begin
                m_active = 0; m_err = 0; e_to = 0; e_emask = '0;
            end
        end else if (m_active) begin
            if (t == m_acc + 1) begin
                m_pend = m_mask & ~bus.free_next;
                if (m_pend == 2'b00) m_empty = t;
            end else if (m_empty < 0) begin
                m_pend = m_pend & ~bus.free_next;
                if (m_pend == 2'b00) m_empty = t;
                else if (t == m_acc + 1 + TO) begin
                    m_err = 1; e_to = 1; e_emask = m_pend;
                end
            end else if (t == m_empty + 1 + FD) begin
                m_active = 0;
            end
        end else if (bus.drive) begin
            m_active = 1; m_acc = t; m_mask = bus.branch_mask; m_empty = -1;
        end
        e_drive = (m_active && !m_err && m_acc == t) ? m_mask : 2'b00;
        e_free  = m_active && !m_err && (m_empty >= 0) && (t + 1 == m_empty + 1 + FD);
        e_busy  = m_active;
    endtask

    int         free_cnt = 0, last_free = -1;
    int         dn_cnt = 0, last_dn = -1;
    int         busy_cnt = 0, to_rise = -1;
    logic [1:0] last_dn_val = '0;
    logic       prev_to = 0;

    // Per-cycle compare: cyc is the index of the output cycle being checked.
    always @(posedge clk) begin
        model_step(cyc);
        cyc = cyc + 1;
        #1;
        check("drive_next", {30'b0, bus.drive_next}, {30'b0, e_drive});
        check("free", {31'b0, bus.free}, {31'b0, e_free});
        check("busy", {31'b0, bus.busy}, {31'b0, e_busy});
        check("timeout", {31'b0, bus.timeout}, {31'b0, e_to});
        check("overrun", {31'b0, bus.overrun}, {31'b0, e_ovr});
        check("err_mask", {30'b0, bus.err_mask}, {30'b0, e_emask});
        check("free_drive_overlap", {31'b0, bus.free & (|bus.drive_next)}, 32'd0);
        if (bus.free === 1'b1) begin free_cnt++; last_free = cyc; end
        if (bus.drive_next != 2'b00) begin dn_cnt++; last_dn = cyc; last_dn_val = bus.drive_next; end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.timeout === 1'b1 && !prev_to) to_rise = cyc;
        prev_to = bus.timeout;
    end

    task automatic step(input logic d, input logic [1:0] m, input logic [1:0] f, input logic c);
        @(negedge clk);
        bus.drive = d; bus.branch_mask = m; bus.free_next = f; bus.clr_err = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 1'b0);
    endtask

    int t0, b_free, b_dn, b_busy;

    task automatic snap();
        b_free = free_cnt; b_dn = dn_cnt; b_busy = busy_cnt;
    endtask

    task automatic basic_fork(input string tag);
        snap();
        step(1'b1, 2'b11, 2'b00, 1'b0); t0 = cyc;
        idle(2);
        step(1'b0, 2'b00, 2'b01, 1'b0);
        idle(1);
        step(1'b0, 2'b00, 2'b10, 1'b0);
        idle(5);
        check({tag, "_free_count"}, free_cnt - b_free, 1);
        check({tag, "_free_cycle"}, last_free - t0, 8);
        check({tag, "_drive_count"}, dn_cnt - b_dn, 1);
        check({tag, "_drive_cycle"}, last_dn - t0, 1);
        check({tag, "_drive_value"}, {30'b0, last_dn_val}, 32'd3);
        check({tag, "_busy_cycles"}, busy_cnt - b_busy, 8);
        check({tag, "_idle_after"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.drive = 1'b0; bus.branch_mask = '0; bus.free_next = '0; bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_free", {31'b0, bus.free}, 32'd0);
        check("reset_drive_next", {30'b0, bus.drive_next}, 32'd0);
        check("reset_flags", {29'b0, bus.timeout, bus.overrun, |bus.err_mask}, 32'd0);
        rst = 1'b0;
        idle(2);

        basic_fork("t1");

        // masked branch with a spurious free on the disabled one
        snap();
        step(1'b1, 2'b10, 2'b00, 1'b0); t0 = cyc;
        idle(1);
        step(1'b0, 2'b00, 2'b01, 1'b0);
        idle(1);
        step(1'b0, 2'b00, 2'b10, 1'b0);
        idle(5);
        check("t2_free_cycle", last_free - t0, 7);
        check("t2_free_count", free_cnt - b_free, 1);
        check("t2_drive_value", {30'b0, last_dn_val}, 32'd2);
        check("t2_no_error", {30'b0, bus.timeout, bus.overrun}, 32'd0);

        // watchdog, then drive in ERR, then drive+clear together
        snap();
        step(1'b1, 2'b11, 2'b00, 1'b0); t0 = cyc;
        idle(1);
        step(1'b0, 2'b00, 2'b01, 1'b0);
        idle(10);
        check("t3_timeout_cycle", to_rise - t0, 10);
        check("t3_timeout", {31'b0, bus.timeout}, 32'd1);
        check("t3_err_mask", {30'b0, bus.err_mask}, 32'd2);
        check("t3_busy_in_err", {31'b0, bus.busy}, 32'd1);
        check("t3_no_free", free_cnt - b_free, 0);
        step(1'b1, 2'b11, 2'b00, 1'b0);
        idle(1);
        check("t3_overrun_in_err", {31'b0, bus.overrun}, 32'd1);
        check("t3_still_err", {31'b0, bus.timeout}, 32'd1);
        step(1'b1, 2'b11, 2'b00, 1'b1);
        idle(1);
        check("t3_clear_flags", {29'b0, bus.timeout, bus.overrun, |bus.err_mask}, 32'd0);
        check("t3_idle_after_clear", {31'b0, bus.busy}, 32'd0);
        idle(3);
        check("t3_drive_count", dn_cnt - b_dn, 1);

        // overrun during WAIT
        snap();
        step(1'b1, 2'b11, 2'b00, 1'b0); t0 = cyc;
        idle(2);
        step(1'b1, 2'b11, 2'b00, 1'b0);
        step(1'b0, 2'b00, 2'b11, 1'b0);
        idle(5);
        check("t4_overrun", {31'b0, bus.overrun}, 32'd1);
        check("t4_free_count", free_cnt - b_free, 1);
        check("t4_free_cycle", last_free - t0, 7);
        check("t4_drive_count", dn_cnt - b_dn, 1);
        step(1'b0, 2'b00, 2'b00, 1'b1);
        idle(1);
        check("t4_clear_outside_err", {31'b0, bus.overrun}, 32'd0);
        check("t4_still_idle", {31'b0, bus.busy}, 32'd0);

        // empty mask
        snap();
        step(1'b1, 2'b00, 2'b00, 1'b0); t0 = cyc;
        idle(6);
        check("t5a_free_cycle", last_free - t0, 4);
        check("t5a_no_drive", dn_cnt - b_dn, 0);

        // free arriving in the ISSUE cycle
        snap();
        step(1'b1, 2'b11, 2'b00, 1'b0); t0 = cyc;
        step(1'b0, 2'b00, 2'b11, 1'b0);
        idle(5);
        check("t5b_free_cycle", last_free - t0, 4);
        check("t5b_free_count", free_cnt - b_free, 1);

        // reset while in DELAY (free would have come at cycle 5)
        snap();
        step(1'b1, 2'b11, 2'b00, 1'b0); t0 = cyc;
        step(1'b0, 2'b00, 2'b01, 1'b0);
        step(1'b0, 2'b00, 2'b10, 1'b0);
        idle(1);
        @(negedge clk);
        bus.drive = 1'b0; bus.free_next = '0;
        rst = 1'b1;
        @(negedge clk);
        check("t6_outputs_zero",
              {26'b0, bus.busy, bus.free, |bus.drive_next, bus.timeout, bus.overrun, |bus.err_mask},
              32'd0);
        rst = 1'b0;
        idle(3);
        check("t6_no_free", free_cnt - b_free, 0);

        basic_fork("t6_fresh");

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
